wb_regfile: RTL and testbench

- Writeback-stage consumer of the mem_wb pipeline register.
- Holds the eight Y86 program registers and commits the E and M write ports each cycle.
- Provides two combinational read ports, with write-through bypass, to decode.
- Tracks processor status: sticky halt/exception latch and a retired-instruction counter.

---
 rtl/wb_regfile_pkg.sv | 35 +++
 rtl/wb_status.sv | 58 +++++
 rtl/wb_regfile.sv | 73 +++++++
 tb/tb_wb_regfile.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared Y86 writeback definitions: register ids, status codes and the status FSM encoding.
package wb_regfile_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int STAT_W = 4;

  localparam logic [BYTE_W-1:0] REAX  = 8'h00;
  localparam logic [BYTE_W-1:0] RECX  = 8'h01;
  localparam logic [BYTE_W-1:0] REDX  = 8'h02;
  localparam logic [BYTE_W-1:0] REBX  = 8'h03;
  localparam logic [BYTE_W-1:0] RESP  = 8'h04;
  localparam logic [BYTE_W-1:0] REBP  = 8'h05;
  localparam logic [BYTE_W-1:0] RESI  = 8'h06;
  localparam logic [BYTE_W-1:0] REDI  = 8'h07;
  localparam logic [BYTE_W-1:0] RNONE = 8'h0F;

  localparam logic [STAT_W-1:0] SBUB = 4'd0;
  localparam logic [STAT_W-1:0] SAOK = 4'd1;
  localparam logic [STAT_W-1:0] SHLT = 4'd2;
  localparam logic [STAT_W-1:0] SADR = 4'd3;
  localparam logic [STAT_W-1:0] SINS = 4'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } wb_state_e;

  // Any stat that is neither bubble nor AOK stops the machine; unknown codes report as SINS.
  function automatic logic [STAT_W-1:0] fault_code(input logic [STAT_W-1:0] s);
    if (s == SHLT || s == SADR || s == SINS) return s;
    return SINS;
  endfunction

endpackage

// File: rtl/wb_status.sv
// Writeback status tracker: RUN/STOP FSM, architectural status latch and saturating retire counter.
module wb_status
  import wb_regfile_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] wb_stat,
  output logic              commit_en,
  output logic [STAT_W-1:0] cpu_stat,
  output logic [CNT_W-1:0]  retired,
  output wb_state_e         state
);

  wb_state_e         state_q, state_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic [CNT_W-1:0]  ret_q, ret_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stat_q  <= SAOK;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    ret_d   = ret_q;
    unique case (state_q)
      ST_RUN: begin
        if (wb_stat == SAOK) begin
          if (ret_q != '1) ret_d = ret_q + 1'b1;
        end else if (wb_stat != SBUB) begin
          stat_d  = fault_code(wb_stat);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Frozen until reset.
        state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  assign commit_en = (state_q == ST_RUN) && (wb_stat == SAOK);
  assign cpu_stat  = stat_q;
  assign retired   = ret_q;
  assign state     = state_q;

endmodule

// File: rtl/wb_regfile.sv
// Y86 writeback register file: two write ports (M beats E), two bypassed combinational read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] wb_valE,
  input  logic [WORD_W-1:0] wb_valM,
  input  logic [BYTE_W-1:0] wb_dstE,
  input  logic [BYTE_W-1:0] wb_dstM,
  input  logic [STAT_W-1:0] wb_stat,
  input  logic [BYTE_W-1:0] d_srcA,
  input  logic [BYTE_W-1:0] d_srcB,
  output logic [WORD_W-1:0] d_rvalA,
  output logic [WORD_W-1:0] d_rvalB,
  output logic [STAT_W-1:0] cpu_stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [WORD_W-1:0] regs [NREGS];
  logic              commit_en;
  logic              we_e, we_m;
  wb_state_e         status_state;

  wb_status #(.CNT_W(CNT_W)) u_status (
    .clk       (clk),
    .rst       (rst),
    .wb_stat   (wb_stat),
    .commit_en (commit_en),
    .cpu_stat  (cpu_stat),
    .retired   (retired),
    .state     (status_state)
  );

  assign halted = (status_state == ST_STOP);

  function automatic logic id_ok(input logic [BYTE_W-1:0] id);
    return {{(32-BYTE_W){1'b0}}, id} < 32'(NREGS);
  endfunction

  assign we_e = commit_en && id_ok(wb_dstE);
  assign we_m = commit_en && id_ok(wb_dstM);

  // M is written after E so a shared destination ends up holding valM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_e) regs[wb_dstE[IDX_W-1:0]] <= wb_valE;
      if (we_m) regs[wb_dstM[IDX_W-1:0]] <= wb_valM;
    end
  end

  // Same-cycle writes are forwarded so decode never needs its own writeback bypass.
  function automatic logic [WORD_W-1:0] read_port(input logic [BYTE_W-1:0] src);
    if (rst || !id_ok(src))          return '0;
    if (we_m && (wb_dstM == src))    return wb_valM;
    if (we_e && (wb_dstE == src))    return wb_valE;
    return regs[src[IDX_W-1:0]];
  endfunction

  always_comb begin
    d_rvalA = read_port(d_srcA);
    d_rvalB = read_port(d_srcB);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic against an array model.
module tb_wb_regfile;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_valE, wb_valM;
  logic [7:0]  wb_dstE, wb_dstM;
  logic [3:0]  wb_stat;
  logic [7:0]  d_srcA, d_srcB;
  logic [31:0] d_rvalA, d_rvalB;
  logic [3:0]  cpu_stat;
  logic        halted;
  logic [CW-1:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state as plain arrays/ints.
  logic [31:0] m_regs [8];
  logic [3:0]  m_stat;
  logic        m_halted;
  int          m_ret;

  wb_regfile #(.NREGS(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .wb_valE(wb_valE), .wb_valM(wb_valM),
    .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
    .wb_stat(wb_stat),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .cpu_stat(cpu_stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
      m_stat = 4'd1; m_halted = 1'b0; m_ret = 0;
    end else if (!m_halted) begin
      if (wb_stat == 4'd1) begin
        if (wb_dstE < 8) m_regs[wb_dstE[2:0]] = wb_valE;
        if (wb_dstM < 8) m_regs[wb_dstM[2:0]] = wb_valM;
        if (m_ret < CNT_MAX) m_ret++;
      end else if (wb_stat != 4'd0) begin
        m_stat   = (wb_stat >= 4'd2 && wb_stat <= 4'd4) ? wb_stat : 4'd4;
        m_halted = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] src);
    if (rst || src >= 8) return 32'h0;
    if (!m_halted && wb_stat == 4'd1) begin
      if (wb_dstM == src) return wb_valM;
      if (wb_dstE == src) return wb_valE;
    end
    return m_regs[src[2:0]];
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic r, input logic [3:0] st,
                       input logic [7:0] de, input logic [31:0] ve,
                       input logic [7:0] dm, input logic [31:0] vm,
                       input logic [7:0] sa, input logic [7:0] sb);
    rst = r; wb_stat = st;
    wb_dstE = de; wb_valE = ve;
    wb_dstM = dm; wb_valM = vm;
    d_srcA = sa; d_srcB = sb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 4'd1, 8'd5, 32'hdead, 8'd6, 32'hbeef, 8'd5, 8'd6);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0 || d_rvalB !== 32'h0) begin
      n_fail++; $display("FAIL rst_force_reads: got %h/%h exp 0/0", d_rvalA, d_rvalB);
    end
    tick(); tick();
    drive(0, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd0, 8'd0);
    for (int i = 0; i < 16; i += 2) begin
      d_srcA = 8'(i); d_srcB = 8'(i + 1);
      #1;
      n_tests++;
      if (d_rvalA !== 32'h0 || d_rvalB !== 32'h0) begin
        n_fail++; $display("FAIL reset_read id%0d: got %h/%h exp 0/0", i, d_rvalA, d_rvalB);
      end
    end
    n_tests++;
    if (cpu_stat !== 4'd1 || halted !== 1'b0 || retired !== 4'd0) begin
      n_fail++; $display("FAIL reset_status: got stat=%0d halt=%0b ret=%0d exp 1/0/0", cpu_stat, halted, retired);
    end
  endtask

  task automatic test_dual_write();
    drive(0, 4'd1, 8'd0, 32'h11, 8'd3, 32'h22, 8'd0, 8'd3);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h11 || d_rvalB !== 32'h22) begin
      n_fail++; $display("FAIL dual_bypass: got %h/%h exp 11/22", d_rvalA, d_rvalB);
    end
    tick();
    drive(0, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd0, 8'd3);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h11 || d_rvalB !== 32'h22 || retired !== 4'd1) begin
      n_fail++; $display("FAIL dual_stored: got %h/%h ret=%0d exp 11/22 ret=1", d_rvalA, d_rvalB, retired);
    end
  endtask

  task automatic test_conflict();
    drive(0, 4'd1, 8'd4, 32'hAAAA, 8'd4, 32'hBBBB, 8'd4, 8'd4);
    #1;
    n_tests++;
    if (d_rvalA !== 32'hBBBB) begin
      n_fail++; $display("FAIL conflict_bypass: got %h exp 0000bbbb", d_rvalA);
    end
    tick();
    drive(0, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd4, 8'd0);
    #1;
    n_tests++;
    if (d_rvalA !== 32'hBBBB || d_rvalB !== 32'h11 || retired !== 4'd2) begin
      n_fail++; $display("FAIL conflict_stored: got %h/%h ret=%0d exp bbbb/11 ret=2", d_rvalA, d_rvalB, retired);
    end
  endtask

  task automatic test_bubble_rnone();
    drive(0, 4'd0, 8'd1, 32'h1234, 8'h0F, 32'h0, 8'd1, 8'd1);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0) begin
      n_fail++; $display("FAIL bubble_no_bypass: got %h exp 0", d_rvalA);
    end
    tick();
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0 || retired !== 4'd2) begin
      n_fail++; $display("FAIL bubble_no_write: got %h ret=%0d exp 0 ret=2", d_rvalA, retired);
    end
    drive(0, 4'd1, 8'h0F, 32'h5555, 8'd9, 32'h6666, 8'h0F, 8'd9);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0 || d_rvalB !== 32'h0) begin
      n_fail++; $display("FAIL invalid_src_read: got %h/%h exp 0/0", d_rvalA, d_rvalB);
    end
    tick();
    drive(0, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd0, 8'd1);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h11 || d_rvalB !== 32'h0 || retired !== 4'd3) begin
      n_fail++; $display("FAIL rnone_write: got %h/%h ret=%0d exp 11/0 ret=3", d_rvalA, d_rvalB, retired);
    end
  endtask

  task automatic test_exception();
    drive(0, 4'd3, 8'h0F, 32'h0, 8'd2, 32'h5, 8'd2, 8'd0);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0) begin
      n_fail++; $display("FAIL sadr_no_bypass: got %h exp 0", d_rvalA);
    end
    tick();
    n_tests++;
    if (cpu_stat !== 4'd3 || halted !== 1'b1 || retired !== 4'd3) begin
      n_fail++; $display("FAIL sadr_status: got stat=%0d halt=%0b ret=%0d exp 3/1/3", cpu_stat, halted, retired);
    end
    drive(0, 4'd1, 8'd2, 32'h77, 8'd0, 32'h88, 8'd2, 8'd0);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0 || d_rvalB !== 32'h11) begin
      n_fail++; $display("FAIL halted_no_bypass: got %h/%h exp 0/11", d_rvalA, d_rvalB);
    end
    tick();
    wb_stat = 4'd2;
    tick();
    wb_stat = 4'd0;
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0 || d_rvalB !== 32'h11 || retired !== 4'd3 || cpu_stat !== 4'd3 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halted_frozen: got %h/%h ret=%0d stat=%0d halt=%0b exp 0/11 3/3/1",
                         d_rvalA, d_rvalB, retired, cpu_stat, halted);
    end
    drive(1, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd0, 8'd3);
    tick();
    rst = 0;
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0 || d_rvalB !== 32'h0 || cpu_stat !== 4'd1 || halted !== 1'b0 || retired !== 4'd0) begin
      n_fail++; $display("FAIL exc_reset_recover: got %h/%h stat=%0d halt=%0b ret=%0d exp 0/0 1/0/0",
                         d_rvalA, d_rvalB, cpu_stat, halted, retired);
    end
  endtask

  task automatic test_reset_during_write();
    drive(0, 4'd1, 8'd6, 32'h42, 8'h0F, 32'h0, 8'd6, 8'd6);
    tick();
    drive(1, 4'd1, 8'd5, 32'h7, 8'h0F, 32'h0, 8'd5, 8'd6);
    tick();
    drive(0, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd5, 8'd6);
    #1;
    n_tests++;
    if (d_rvalA !== 32'h0 || d_rvalB !== 32'h0 || retired !== 4'd0) begin
      n_fail++; $display("FAIL rst_during_write: got %h/%h ret=%0d exp 0/0 ret=0", d_rvalA, d_rvalB, retired);
    end
  endtask

  task automatic test_unknown_stat();
    drive(0, 4'd11, 8'd1, 32'h99, 8'h0F, 32'h0, 8'd1, 8'd1);
    tick();
    n_tests++;
    if (cpu_stat !== 4'd4 || halted !== 1'b1) begin
      n_fail++; $display("FAIL unknown_stat: got stat=%0d halt=%0b exp 4/1", cpu_stat, halted);
    end
    drive(1, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd0, 8'd0);
    tick();
    rst = 0;
  endtask

  task automatic test_saturate();
    drive(0, 4'd1, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd0, 8'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_tests++;
      if (retired !== 4'((i > 15) ? 15 : i)) begin
        n_fail++; $display("FAIL saturate step%0d: got %0d exp %0d", i, retired, (i > 15) ? 15 : i);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] de, dm;
    logic [3:0] st;
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      st = 4'd1;
      else if (r < 85) st = 4'd0;
      else if (r < 97) st = 4'($urandom_range(0, 1));
      else             st = 4'($urandom_range(2, 15));
      r  = $urandom_range(0, 9);
      de = (r < 8) ? 8'(r) : ((r == 8) ? 8'h0F : 8'($urandom_range(8, 14)));
      r  = $urandom_range(0, 9);
      dm = (r < 8) ? 8'(r) : ((r == 8) ? 8'h0F : 8'($urandom_range(8, 14)));
      drive(($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 7) == 0),
            st, de, $urandom, dm, $urandom,
            8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
      #1;
      n_tests++;
      if (d_rvalA !== exp_read(d_srcA) || d_rvalB !== exp_read(d_srcB)) begin
        n_fail++; $display("FAIL rand_read c%0d: got %h/%h exp %h/%h", c, d_rvalA, d_rvalB,
                           exp_read(d_srcA), exp_read(d_srcB));
      end
      tick();
      n_tests++;
      if (cpu_stat !== m_stat || halted !== m_halted || retired !== CW'(m_ret)) begin
        n_fail++; $display("FAIL rand_status c%0d: got stat=%0d halt=%0b ret=%0d exp %0d/%0b/%0d",
                           c, cpu_stat, halted, retired, m_stat, m_halted, m_ret);
      end
    end
  endtask

  initial begin
    drive(1, 4'd0, 8'h0F, 32'h0, 8'h0F, 32'h0, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_stat = 4'd1; m_halted = 1'b0; m_ret = 0;
    @(negedge clk);
    test_reset();
    test_dual_write();
    test_conflict();
    test_bubble_rnone();
    test_exception();
    test_reset_during_write();
    test_unknown_stat();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
